dual_pipe_merger: RTL and testbench
===================================

// Module: dual_pipe_merger
// PURPOSE
//   Downstream stage of the dual-pipeline top: consumes out_data_1/out_valid_1 and out_data_2/out_valid_2.
//   Buffers each stream in its own FIFO and merges both onto one valid/ready output with round-robin arbitration.
//   Drives the global stall back to both pipelines so that no word is lost when the sink backpressures.
// PARAMETERS
//   DATA_W        32  width of each data word
//   FIFO_DEPTH    4   entries per stream FIFO; power of 2, >= 4
//   STALL_MARGIN  2   free-slot margin that triggers stall; covers in-flight words, >= 2
// PORTS
//   clk           in   1       single clock; all state on posedge
//   reset         in   1       asynchronous, active-high; clears all state
//   in_data_1     in   DATA_W  pipeline 1 result
//   in_valid_1    in   1       pipeline 1 result valid
//   in_data_2     in   DATA_W  pipeline 2 result
//   in_valid_2    in   1       pipeline 2 result valid
//   stall         out  1       registered global stall to both pipelines
//   out_data      out  DATA_W  merged output word
//   out_src       out  1       source of out_data: 0 = pipe 1, 1 = pipe 2
//   out_valid     out  1       out_data/out_src valid
//   out_ready     in   1       sink accepts the word when out_valid && out_ready
//   overflow      out  1       sticky: a word was dropped
// BEHAVIOUR
//   Reset values: stall=0, out_valid=0, out_data=0, out_src=0, overflow=0; FIFOs empty; rr_last=1, so pipe 1 wins first.
//   Write side:
//     - in_valid_k writes in_data_k into FIFO k every cycle it is high, independent of stall.
//     - Full FIFO k with a same-cycle pop of k: write accepted.
//     - Full FIFO k with no pop of k: word dropped, overflow<=1, and it holds until reset.
//   Output register (holds one word):
//     - Loads when empty (!out_valid) or when the current word is accepted (out_valid && out_ready).
//     - While out_valid && !out_ready, out_data and out_src hold stable; no pop occurs.
//   Arbitration, on a load opportunity:
//     - Only one FIFO non-empty: pop that FIFO.
//     - Both FIFOs non-empty: pop the FIFO != rr_last.
//     - rr_last <= the popped source.
//     - Neither FIFO non-empty: out_valid <= 0.
//   Latency: a word presented in cycle N, with its FIFO empty and the output register free, is on out_data after edge N+1.
//   FIFO k supports simultaneous read and write; its count is unchanged by that cycle.
//   Pointers wrap modulo FIFO_DEPTH; count has log2(FIFO_DEPTH)+1 bits.
//   stall <= (count_1 >= FIFO_DEPTH-STALL_MARGIN) || (count_2 >= FIFO_DEPTH-STALL_MARGIN), using post-update counts.
//     - Registered, so stall takes effect one cycle late; STALL_MARGIN absorbs the word already in flight.
//     - stall deasserts on the edge after both counts fall below the threshold.
//   Reset mid-operation: all buffered and in-register words are discarded immediately; no partial output.
// CONFIGURATION
//   PERF_CNT_EN defined:
//     - Adds outputs acc_cnt_1, acc_cnt_2 and stall_cnt, each 32 bits, reset 0.
//     - acc_cnt_k += 1 per word of source k accepted by the sink.
//     - stall_cnt += 1 per cycle stall=1.
//     - All three counters wrap at 2^32.
//   PERF_CNT_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//   1. Reset, then out_ready=1; pipe 1 sends 5 with pipe 2 idle.
//      -> Cycle N+1: out_data=5, out_src=0, out_valid=1; stall stays 0.
//   2. Both valid every cycle with values 1,2,3 on pipe 1 and 101,102,103 on pipe 2; out_ready=1.
//      -> Output order 1,101,2,102,3,103 with out_src alternating 0,1.
//   3. out_ready=0, both streams valid, defaults.
//      -> stall=1 the cycle after either count reaches 2; overflow stays 0 once both pipelines honour stall.
//      -> out_data holds stable.
//   4. Same as 3, but the pipeline ignores stall (driven directly) for 8 cycles.
//      -> overflow=1 after the 5th word into a FIFO, and stays 1.
//      -> The first 4 words of that FIFO are delivered intact.
//   5. Assert reset while both FIFOs hold 3 words and out_valid=1.
//      -> Same cycle: out_valid=0, stall=0, overflow=0; no old word appears after release.
//   6. With PERF_CNT_EN, run 10 words per stream with 4 stalled cycles.
//      -> acc_cnt_1=10, acc_cnt_2=10, stall_cnt=4.

Source files
------------

// File: rtl/dual_pipe_merger.sv
// Buffers two pipeline result streams in per-stream FIFOs and merges them round-robin onto
// one valid/ready output, with a registered stall back to both pipelines. PERF_CNT_EN adds counters.
module dual_pipe_merger #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STALL_MARGIN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic              in_valid_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic              in_valid_2,
  output logic              stall,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       acc_cnt_1,
  output logic [31:0]       acc_cnt_2,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] STALL_TH = (AW+1)'(FIFO_DEPTH - STALL_MARGIN);

  logic [DATA_W-1:0] r_mem [2][FIFO_DEPTH];
  logic [AW-1:0]     r_wptr [2];
  logic [AW-1:0]     r_rptr [2];
  logic [AW:0]       r_cnt [2];
  logic              r_rr_last;  // 0 = pipe 1 popped last, 1 = pipe 2
  logic              r_stall;
  logic              r_overflow;
  logic              r_out_valid;
  logic              r_out_src;
  logic [DATA_W-1:0] r_out_data;

  logic [DATA_W-1:0] w_in_data [2];
  logic              w_in_valid [2];
  logic              w_ne [2];
  logic              w_full [2];
  logic              w_pop [2];
  logic              w_wr [2];
  logic              w_drop [2];
  logic [AW:0]       w_cnt_nxt [2];
  logic              w_load;

  always_comb begin
    w_in_data[0]  = in_data_1;
    w_in_data[1]  = in_data_2;
    w_in_valid[0] = in_valid_1;
    w_in_valid[1] = in_valid_2;
    w_load        = !r_out_valid || out_ready;
    for (int k = 0; k < 2; k++) begin
      w_ne[k]   = (r_cnt[k] != '0);
      w_full[k] = (r_cnt[k] == FULL_CNT);
    end
    // Contention goes to the stream that did not win last time.
    w_pop[0] = w_load && w_ne[0] && (!w_ne[1] || r_rr_last);
    w_pop[1] = w_load && w_ne[1] && (!w_ne[0] || !r_rr_last);
    for (int k = 0; k < 2; k++) begin
      w_wr[k]      = w_in_valid[k] && (!w_full[k] || w_pop[k]);
      w_drop[k]    = w_in_valid[k] && w_full[k] && !w_pop[k];
      w_cnt_nxt[k] = r_cnt[k] + {{AW{1'b0}}, w_wr[k]} - {{AW{1'b0}}, w_pop[k]};
    end
  end

  // Storage carries no reset; emptiness is tracked by the counts alone.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (w_wr[k]) r_mem[k][r_wptr[k]] <= w_in_data[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
        r_cnt[k]  <= '0;
      end
      r_rr_last   <= 1'b1;
      r_stall     <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_src   <= 1'b0;
      r_out_data  <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_wr[k])  r_wptr[k] <= r_wptr[k] + 1'b1;
        if (w_pop[k]) r_rptr[k] <= r_rptr[k] + 1'b1;
        r_cnt[k] <= w_cnt_nxt[k];
      end
      if (w_drop[0] || w_drop[1]) r_overflow <= 1'b1;
      r_stall <= (w_cnt_nxt[0] >= STALL_TH) || (w_cnt_nxt[1] >= STALL_TH);
      if (w_load) begin
        if (w_pop[0]) begin
          r_out_data  <= r_mem[0][r_rptr[0]];
          r_out_src   <= 1'b0;
          r_out_valid <= 1'b1;
          r_rr_last   <= 1'b0;
        end else if (w_pop[1]) begin
          r_out_data  <= r_mem[1][r_rptr[1]];
          r_out_src   <= 1'b1;
          r_out_valid <= 1'b1;
          r_rr_last   <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign stall     = r_stall;
  assign overflow  = r_overflow;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;
  assign out_data  = r_out_data;

`ifdef PERF_CNT_EN
  logic [31:0] r_acc_cnt_1;
  logic [31:0] r_acc_cnt_2;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc_cnt_1 <= '0;
      r_acc_cnt_2 <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_out_valid && out_ready && !r_out_src) r_acc_cnt_1 <= r_acc_cnt_1 + 32'd1;
      if (r_out_valid && out_ready && r_out_src)  r_acc_cnt_2 <= r_acc_cnt_2 + 32'd1;
      if (r_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign acc_cnt_1 = r_acc_cnt_1;
  assign acc_cnt_2 = r_acc_cnt_2;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dual_pipe_merger.sv
// Self-checking bench for dual_pipe_merger: directed vector table, hand-written corner sequences
// and randomized traffic against a queue-based reference model.
module tb_dual_pipe_merger;
  localparam int unsigned DW     = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MARGIN = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data_1 = '0;
  logic          in_valid_1 = 1'b0;
  logic [DW-1:0] in_data_2 = '0;
  logic          in_valid_2 = 1'b0;
  logic          out_ready = 1'b0;
  logic          stall;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic          out_valid;
  logic          overflow;
`ifdef PERF_CNT_EN
  logic [31:0]   acc_cnt_1;
  logic [31:0]   acc_cnt_2;
  logic [31:0]   stall_cnt;
`endif

  dual_pipe_merger #(
    .DATA_W      (DW),
    .FIFO_DEPTH  (DEPTH),
    .STALL_MARGIN(MARGIN)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_data_1 (in_data_1),
    .in_valid_1(in_valid_1),
    .in_data_2 (in_data_2),
    .in_valid_2(in_valid_2),
    .stall     (stall),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
`ifdef PERF_CNT_EN
    ,
    .acc_cnt_1 (acc_cnt_1),
    .acc_cnt_2 (acc_cnt_2),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: two bounded queues feeding a one-word output slot.
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  logic          m_valid, m_src, m_rr, m_stall, m_ovf;
  logic [DW-1:0] m_data;
  logic [31:0]   m_acc1, m_acc2, m_scnt;

  task automatic model_reset();
    q1.delete(); q2.delete();
    m_valid = 0; m_src = 0; m_rr = 1; m_stall = 0; m_ovf = 0; m_data = '0;
    m_acc1 = 0; m_acc2 = 0; m_scnt = 0;
  endtask

  task automatic model_update();
    if (reset) begin
      model_reset();
      return;
    end
    if (m_valid && out_ready) begin
      if (m_src) m_acc2++; else m_acc1++;
    end
    if (m_stall) m_scnt++;
    if (!m_valid || out_ready) begin
      if (q1.size() > 0 && (q2.size() == 0 || m_rr == 1'b1)) begin
        m_data = q1.pop_front(); m_src = 0; m_rr = 0; m_valid = 1;
      end else if (q2.size() > 0) begin
        m_data = q2.pop_front(); m_src = 1; m_rr = 1; m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    if (in_valid_1) begin
      if (q1.size() < DEPTH) q1.push_back(in_data_1); else m_ovf = 1;
    end
    if (in_valid_2) begin
      if (q2.size() < DEPTH) q2.push_back(in_data_2); else m_ovf = 1;
    end
    m_stall = (q1.size() >= DEPTH - MARGIN) || (q2.size() >= DEPTH - MARGIN);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check("model out_valid", out_valid, m_valid);
    check("model stall", stall, m_stall);
    check("model overflow", overflow, m_ovf);
    if (m_valid) begin
      check("model out_data", out_data, m_data);
      check("model out_src", out_src, m_src);
    end
`ifdef PERF_CNT_EN
    check("model acc_cnt_1", acc_cnt_1, m_acc1);
    check("model acc_cnt_2", acc_cnt_2, m_acc2);
    check("model stall_cnt", stall_cnt, m_scnt);
`endif
  endtask

  task automatic drive(input logic v1, input logic [DW-1:0] d1, input logic v2,
                       input logic [DW-1:0] d2, input logic rdy);
    in_valid_1 = v1; in_data_1 = d1; in_valid_2 = v2; in_data_2 = d2; out_ready = rdy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, '0, 0, '0, 0);
    cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    bit            rst;
    bit            v1;
    logic [DW-1:0] d1;
    bit            v2;
    logic [DW-1:0] d2;
    bit            rdy;
    bit            e_valid;
    logic [DW-1:0] e_data;
    bit            e_src;
    bit            e_stall;
  } vec_t;

  vec_t          vecs[13];
  logic [DW-1:0] held;
  logic [DW-1:0] sent2[$];
  logic [DW-1:0] got2[$];
  int            sent_a, sent_b;

  initial begin
    model_reset();
    // Single word latency, then round-robin order with both streams busy.
    vecs[0]  = '{1, 0, 0,   0, 0,   1, 0, 0,   0, 0};
    vecs[1]  = '{0, 1, 5,   0, 0,   1, 0, 0,   0, 0};
    vecs[2]  = '{0, 0, 0,   0, 0,   1, 1, 5,   0, 0};
    vecs[3]  = '{0, 0, 0,   0, 0,   1, 0, 0,   0, 0};
    vecs[4]  = '{1, 0, 0,   0, 0,   1, 0, 0,   0, 0};
    vecs[5]  = '{0, 1, 1,   1, 101, 1, 0, 0,   0, 0};
    vecs[6]  = '{0, 1, 2,   1, 102, 1, 1, 1,   0, 1};
    vecs[7]  = '{0, 1, 3,   1, 103, 1, 1, 101, 1, 1};
    vecs[8]  = '{0, 0, 0,   0, 0,   1, 1, 2,   0, 1};
    vecs[9]  = '{0, 0, 0,   0, 0,   1, 1, 102, 1, 0};
    vecs[10] = '{0, 0, 0,   0, 0,   1, 1, 3,   0, 0};
    vecs[11] = '{0, 0, 0,   0, 0,   1, 1, 103, 1, 0};
    vecs[12] = '{0, 0, 0,   0, 0,   1, 0, 0,   0, 0};

    #2;
    for (int i = 0; i < 13; i++) begin
      reset = vecs[i].rst;
      drive(vecs[i].v1, vecs[i].d1, vecs[i].v2, vecs[i].d2, vecs[i].rdy);
      cycle();
      check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_valid);
      check($sformatf("vec%0d stall", i), stall, vecs[i].e_stall);
      if (vecs[i].e_valid || vecs[i].rst) begin
        check($sformatf("vec%0d out_data", i), out_data, vecs[i].e_data);
        check($sformatf("vec%0d out_src", i), out_src, vecs[i].e_src);
      end
      if (vecs[i].rst) check($sformatf("vec%0d overflow", i), overflow, 0);
    end
    reset = 1'b0;

    // Sink blocked, pipelines honour stall: no loss, output word frozen.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(!stall, 32'h100 + i, !stall, 32'h200 + i, 0);
      cycle();
      if (i == 1) held = out_data;
    end
    check("honour stall overflow", overflow, 0);
    check("honour stall stall", stall, 1);
    check("blocked out_data stable", out_data, held);

    // Pipelines ignore stall for 8 cycles: drop, sticky overflow, first 4 words survive.
    do_reset();
    sent2.delete(); got2.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h300 + i, 1, 32'h400 + i, 0);
      sent2.push_back(32'h400 + i);
      cycle();
    end
    check("ignore stall overflow", overflow, 1);
    for (int i = 0; i < 14; i++) begin
      drive(0, '0, 0, '0, 1);
      cycle();
      if (out_valid && out_src) got2.push_back(out_data);
    end
    check("overflow sticky", overflow, 1);
    check("pipe2 delivered count", got2.size(), 4);
    for (int i = 0; i < 4 && i < got2.size(); i++)
      check($sformatf("pipe2 word %0d", i), got2[i], sent2[i]);

    // Asynchronous reset with both FIFOs loaded and the output slot full.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h500 + i, i < 3, 32'h600 + i, 0);
      cycle();
    end
    drive(0, '0, 0, '0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async rst out_valid", out_valid, 0);
    check("async rst stall", stall, 0);
    check("async rst overflow", overflow, 0);
    check("async rst out_data", out_data, 0);
    model_reset();
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(0, '0, 0, '0, 1);
      cycle();
    end

    // Randomized traffic; pipelines mostly honour stall, sink randomly blocks.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic honour;
      honour = ($urandom_range(0, 15) != 0);
      drive(($urandom_range(0, 1) == 1) && (!stall || !honour), $urandom,
            ($urandom_range(0, 1) == 1) && (!stall || !honour), $urandom,
            $urandom_range(0, 3) != 0);
      cycle();
    end

`ifdef PERF_CNT_EN
    // Ten words per stream with a partly blocked sink, then drain.
    do_reset();
    sent_a = 0; sent_b = 0;
    for (int i = 0; i < 60 && (sent_a < 10 || sent_b < 10); i++) begin
      drive(!stall && sent_a < 10, 32'h700 + sent_a, !stall && sent_b < 10, 32'h800 + sent_b,
            (i % 3) != 0);
      if (in_valid_1) sent_a++;
      if (in_valid_2) sent_b++;
      cycle();
    end
    for (int i = 0; i < 20; i++) begin
      drive(0, '0, 0, '0, 1);
      cycle();
    end
    check("perf acc_cnt_1", acc_cnt_1, 10);
    check("perf acc_cnt_2", acc_cnt_2, 10);
    check("perf stall_cnt", stall_cnt, m_scnt);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
